// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and axis-state encoding
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
    localparam int H_START = DEF_H_SYNC + DEF_H_BP;
    localparam int V_START = DEF_V_SYNC + DEF_V_BP;

    // Region order along an axis: sync pulse first, then back porch, active, front porch
    typedef enum logic [1:0] {
        AX_SYNC   = 2'd0,
        AX_BACK   = 2'd1,
        AX_ACTIVE = 2'd2,
        AX_FRONT  = 2'd3
    } axis_state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter and region state
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC_W   = DEF_H_SYNC,
    parameter int BACK_W   = DEF_H_BP,
    parameter int ACTIVE_W = DEF_H_ACTIVE,
    parameter int FRONT_W  = DEF_H_FP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] next_count_o,
    output logic [1:0]       next_state_o,
    output logic             wrap_o
);

    localparam int               TOTAL   = SYNC_W + BACK_W + ACTIVE_W + FRONT_W;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] B_BACK  = CNT_W'(SYNC_W);
    localparam logic [CNT_W-1:0] B_ACT   = CNT_W'(SYNC_W + BACK_W);
    localparam logic [CNT_W-1:0] B_FRONT = CNT_W'(SYNC_W + BACK_W + ACTIVE_W);

    logic [CNT_W-1:0] count_q, count_d;
    axis_state_e      state_d;

    // Next count: step on advance, wrap at the last position, recover from any illegal value
    always_comb begin
        wrap_o  = advance_i && (count_q == LAST);
        count_d = count_q;
        if (count_q > LAST) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    // Region of the upcoming count, so the top can register aligned outputs
    always_comb begin
        state_d = AX_FRONT;
        if (count_d < B_BACK) begin
            state_d = AX_SYNC;
        end else if (count_d < B_ACT) begin
            state_d = AX_BACK;
        end else if (count_d < B_FRONT) begin
            state_d = AX_ACTIVE;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign next_count_o = count_d;
    assign next_state_o = state_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: counters, syncs, de, coordinates, pulses
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);

    logic [CNT_W-1:0] h_count, h_next, v_count, v_next;
    logic [1:0]       h_state_d, v_state_d;
    logic             h_wrap, v_wrap;

    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;

    vga_axis_counter #(
        .SYNC_W   (H_SYNC),
        .BACK_W   (H_BP),
        .ACTIVE_W (H_ACTIVE),
        .FRONT_W  (H_FP)
    ) u_h_axis (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance_i    (pix_ce),
        .count_o      (h_count),
        .next_count_o (h_next),
        .next_state_o (h_state_d),
        .wrap_o       (h_wrap)
    );

    vga_axis_counter #(
        .SYNC_W   (V_SYNC),
        .BACK_W   (V_BP),
        .ACTIVE_W (V_ACTIVE),
        .FRONT_W  (V_FP)
    ) u_v_axis (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance_i    (pix_ce & h_wrap),
        .count_o      (v_count),
        .next_count_o (v_next),
        .next_state_o (v_state_d),
        .wrap_o       (v_wrap)
    );

    // Decode the upcoming raster position so every output lands on the same edge as the counters
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            hsync_d       = (h_state_d == AX_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = (v_state_d == AX_SYNC) ? SYNC_POL : ~SYNC_POL;
            de_d          = (h_state_d == AX_ACTIVE) && (v_state_d == AX_ACTIVE);
            pix_x_d       = de_d ? (h_next - H_START_C) : '0;
            pix_y_d       = (v_state_d == AX_ACTIVE) ? (v_next - V_START_C) : '0;
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
        end
    end

    // Output register stage; reset state (0,0) sits inside both sync regions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= SYNC_POL;
            vsync_q       <= SYNC_POL;
            de_q          <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = h_count;
    assign vcount      = v_count;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench: full-size raster plus a tiny active-high raster
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
    } obs_t;

    // Tiny raster: 10 clocks per line, 7 lines per frame, active window 4x3 at (5,3)
    localparam int S_HS = 2, S_HB = 3, S_HA = 4, S_HF = 1;
    localparam int S_VS = 1, S_VB = 2, S_VA = 3, S_VF = 1;

    logic       clk = 1'b0;
    logic       rst_n0 = 1'b1, rst_n1 = 1'b1;
    logic       ce0 = 1'b1, ce1 = 1'b1;
    logic [9:0] h0, v0, px0, py0, h1, v1, px1, py1;
    logic       hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;
    obs_t       o0, o1, m0, m1;
    obs_t       q0[$], q1[$];
    int         ncmp = 0, nfail = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst_n(rst_n0), .pix_ce(ce0),
        .hcount(h0), .vcount(v0), .hsync(hs0), .vsync(vs0), .de(de0),
        .pix_x(px0), .pix_y(py0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .pix_ce(ce1),
        .hcount(h1), .vcount(v1), .hsync(hs1), .vsync(vs1), .de(de1),
        .pix_x(px1), .pix_y(py1), .line_start(ls1), .frame_start(fs1)
    );

    assign o0 = {h0, v0, hs0, vs0, de0, px0, py0, ls0, fs0};
    assign o1 = {h1, v1, hs1, vs1, de1, px1, py1, ls1, fs1};

    function automatic obs_t reset_obs(logic pol);
        obs_t r;
        r    = '0;
        r.hs = pol;
        r.vs = pol;
        return r;
    endfunction

    function automatic obs_t model_next(obs_t c, logic ce, logic rn,
                                        int hsw, int hbw, int haw, int hfw,
                                        int vsw, int vbw, int vaw, int vfw, logic pol);
        obs_t n;
        int   h, v;
        logic hact, vact;
        if (!rn) return reset_obs(pol);
        n    = c;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (!ce) return n;
        h = int'(c.h);
        v = int'(c.v);
        if (h == hsw + hbw + haw + hfw - 1) begin
            h = 0;
            v = (v == vsw + vbw + vaw + vfw - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
        hact = (h >= hsw + hbw) && (h < hsw + hbw + haw);
        vact = (v >= vsw + vbw) && (v < vsw + vbw + vaw);
        n.h  = 10'(h);
        n.v  = 10'(v);
        n.hs = (h < hsw) ? pol : ~pol;
        n.vs = (v < vsw) ? pol : ~pol;
        n.de = hact && vact;
        n.px = n.de ? 10'(h - hsw - hbw) : 10'd0;
        n.py = vact ? 10'(v - vsw - vbw) : 10'd0;
        n.ls = (h == 0);
        n.fs = (h == 0) && (v == 0);
        return n;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t got, input obs_t exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cmp_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: push model expectations for the current inputs, then compare after the edge
    task automatic step();
        m0 = model_next(m0, ce0, rst_n0, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0);
        q0.push_back(m0);
        m1 = model_next(m1, ce1, rst_n1, S_HS, S_HB, S_HA, S_HF, S_VS, S_VB, S_VA, S_VF, 1'b1);
        q1.push_back(m1);
        @(posedge clk);
        #1;
        cmp_obs("sb0", o0, q0.pop_front());
        cmp_obs("sb1", o1, q1.pop_front());
    endtask

    // Run (tiny raster on a 1-of-2 enable) until the full-size raster reaches (h,v)
    task automatic run_to0(input int h, input int v, input int budget);
        int n;
        n = 0;
        while (!(int'(h0) == h && int'(v0) == v) && n < budget) begin
            ce1 = ~ce1;
            step();
            n++;
        end
        cmp_val("reach0", (int'(h0) == h && int'(v0) == v) ? 1 : 0, 1);
    endtask

    task automatic run_to1(input int h, input int v, input int budget);
        int n;
        n = 0;
        while (!(int'(h1) == h && int'(v1) == v) && n < budget) begin
            ce1 = ~ce1;
            step();
            n++;
        end
        cmp_val("reach1", (int'(h1) == h && int'(v1) == v) ? 1 : 0, 1);
    endtask

    initial begin
        int nce, nclk, nde;
        logic seen;

        // Reset with enables high
        #2;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_obs("rst0", o0, reset_obs(1'b0));
        cmp_obs("rst1", o1, reset_obs(1'b1));
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        m0 = reset_obs(1'b0);
        m1 = reset_obs(1'b1);
        cmp_obs("rel0", o0, reset_obs(1'b0));

        // Full-size raster: hsync edge and active-window boundaries on line 35
        run_to0(95, 0, 200);
        cmp_val("hs_at_95", hs0, 0);
        step();
        cmp_val("hs_at_96", hs0, 1);
        run_to0(143, 35, 30000);
        cmp_val("de_at_143", de0, 0);
        step();
        cmp_val("de_at_144", de0, 1);
        cmp_val("px_at_144", px0, 0);
        cmp_val("py_at_144", py0, 0);
        run_to0(783, 35, 700);
        cmp_val("px_at_783", px0, 639);
        step();
        cmp_val("de_at_784", de0, 0);
        cmp_val("px_at_784", px0, 0);

        // Tiny raster: asynchronous reset mid-frame takes effect before any clock edge
        run_to1(7, 4, 200);
        #2;
        rst_n1 = 1'b0;
        #1;
        cmp_obs("async_rst1", o1, reset_obs(1'b1));
        m1 = reset_obs(1'b1);
        step();
        step();
        rst_n1 = 1'b1;

        // One full frame after release on a 1-of-2 enable
        nce  = 0;
        nclk = 0;
        nde  = 0;
        seen = 1'b0;
        ce1  = 1'b0;
        while (!seen && nclk < 400) begin
            ce1 = ~ce1;
            step();
            nclk++;
            if (ce1) begin
                nce++;
                if (de1) nde++;
            end
            if (fs1) seen = 1'b1;
        end
        cmp_val("frame_seen", seen, 1);
        cmp_val("frame_ce", nce, 70);
        cmp_val("frame_clk", nclk, 139);
        cmp_val("frame_de", nde, 12);

        // Simultaneous wrap: both pulses together at (0,0), then hold with enable low
        cmp_val("wrap_h", h1, 0);
        cmp_val("wrap_v", v1, 0);
        cmp_val("wrap_ls", ls1, 1);
        cmp_val("wrap_fs", fs1, 1);
        cmp_val("wrap_hs_pol", hs1, 1);
        cmp_val("wrap_vs_pol", vs1, 1);
        ce1 = 1'b0;
        step();
        cmp_val("hold_h", h1, 0);
        cmp_val("hold_ls", ls1, 0);
        cmp_val("hold_fs", fs1, 0);
        ce1 = 1'b1;
        step();
        step();
        cmp_val("pol_h2", h1, 2);
        cmp_val("pol_hs_off", hs1, 0);
        cmp_val("pol_vs_on", vs1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
